// File: rtl/axilite_master_traffic_gen.sv
`default_nettype none
// ============================================================================
// Module   : axilite_master_traffic_gen
// Brief    : Bounded AXI4-Lite write(/readback) traffic generator with
//            response checking. Readback phase enabled by the macro
//            AXILITE_TRAFFIC_GEN_READBACK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module axilite_master_traffic_gen #(
    parameter int                    ADDR_WIDTH  = 64,
    parameter int                    DATA_WIDTH  = 64,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 'h4000_0000,
    parameter logic [ADDR_WIDTH-1:0] ADDR_STRIDE = 8,
    parameter logic [DATA_WIDTH-1:0] DATA_SEED   = '0,
    parameter int                    NUM_TXNS    = 16,
    parameter int                    ERR_WIDTH   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready,
    output logic                    busy,
    output logic                    done,
    output logic [ERR_WIDTH-1:0]    error_count
);

    localparam int               IDX_W     = (NUM_TXNS > 1) ? $clog2(NUM_TXNS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_TXNS - 1);
    localparam logic [1:0]       RESP_OKAY = 2'b00;
`ifdef AXILITE_TRAFFIC_GEN_READBACK_EN
    localparam bit               READBACK  = 1'b1;
`else
    localparam bit               READBACK  = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] idx;
    logic             last_idx;
    logic             aw_hs;
    logic             w_hs;
    logic             b_hs;
    logic             ar_hs;
    logic             r_hs;
    logic             wr_both;
    logic             rd_bad;
    logic             err_hit;
    logic             run_end;

    assign aw_hs       = m_axi_awvalid & m_axi_awready;
    assign w_hs        = m_axi_wvalid & m_axi_wready;
    assign b_hs        = m_axi_bvalid & m_axi_bready;
    assign last_idx    = (idx == LAST_IDX);
    assign m_axi_wstrb = '1;
    // A channel counts as finished once its valid has already dropped.
    assign wr_both     = (aw_hs | ~m_axi_awvalid) & (w_hs | ~m_axi_wvalid);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        err_hit    = 1'b0;
        run_end    = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) state_next = WR_REQ;
            end
            WR_REQ: begin
                if (wr_both) state_next = WR_RESP;
            end
            WR_RESP: begin
                if (b_hs) begin
                    err_hit = (m_axi_bresp != RESP_OKAY);
                    if (!last_idx) begin
                        state_next = WR_REQ;
                    end else if (READBACK) begin
                        state_next = RD_REQ;
                    end else begin
                        state_next = DONE;
                        run_end    = 1'b1;
                    end
                end
            end
            RD_REQ: begin
                if (ar_hs) state_next = RD_RESP;
            end
            RD_RESP: begin
                if (r_hs) begin
                    err_hit = rd_bad;
                    if (!last_idx) begin
                        state_next = RD_REQ;
                    end else begin
                        state_next = DONE;
                        run_end    = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // wdata doubles as the expected read data during the readback phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_awaddr  <= BASE_ADDR;
            m_axi_wdata   <= DATA_SEED;
            idx           <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error_count   <= '0;
        end else begin
            if (err_hit && (error_count != '1)) begin
                error_count <= error_count + ERR_WIDTH'(1);
            end
            if (run_end) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        idx           <= '0;
                        error_count   <= '0;
                        done          <= 1'b0;
                        busy          <= 1'b1;
                        m_axi_awvalid <= 1'b1;
                        m_axi_wvalid  <= 1'b1;
                        m_axi_awaddr  <= BASE_ADDR;
                        m_axi_wdata   <= DATA_SEED;
                    end
                end
                WR_REQ: begin
                    if (aw_hs)   m_axi_awvalid <= 1'b0;
                    if (w_hs)    m_axi_wvalid  <= 1'b0;
                    if (wr_both) m_axi_bready  <= 1'b1;
                end
                WR_RESP: begin
                    if (b_hs) begin
                        m_axi_bready <= 1'b0;
                        if (!last_idx) begin
                            idx           <= idx + IDX_W'(1);
                            m_axi_awaddr  <= m_axi_awaddr + ADDR_STRIDE;
                            m_axi_wdata   <= m_axi_wdata + DATA_WIDTH'(1);
                            m_axi_awvalid <= 1'b1;
                            m_axi_wvalid  <= 1'b1;
                        end else begin
                            idx          <= '0;
                            m_axi_awaddr <= BASE_ADDR;
                            m_axi_wdata  <= DATA_SEED;
                        end
                    end
                end
                RD_RESP: begin
                    if (r_hs) begin
                        if (!last_idx) begin
                            idx         <= idx + IDX_W'(1);
                            m_axi_wdata <= m_axi_wdata + DATA_WIDTH'(1);
                        end else begin
                            idx         <= '0;
                            m_axi_wdata <= DATA_SEED;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef AXILITE_TRAFFIC_GEN_READBACK_EN
    assign ar_hs  = m_axi_arvalid & m_axi_arready;
    assign r_hs   = m_axi_rvalid & m_axi_rready;
    assign rd_bad = (m_axi_rresp != RESP_OKAY) | (m_axi_rdata != m_axi_wdata);

    always_ff @(posedge clk) begin
        if (rst) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            m_axi_araddr  <= BASE_ADDR;
        end else begin
            case (state)
                WR_RESP: begin
                    if (b_hs && last_idx) begin
                        m_axi_arvalid <= 1'b1;
                        m_axi_araddr  <= BASE_ADDR;
                    end
                end
                RD_REQ: begin
                    if (ar_hs) begin
                        m_axi_arvalid <= 1'b0;
                        m_axi_rready  <= 1'b1;
                    end
                end
                RD_RESP: begin
                    if (r_hs) begin
                        m_axi_rready <= 1'b0;
                        if (!last_idx) begin
                            m_axi_araddr  <= m_axi_araddr + ADDR_STRIDE;
                            m_axi_arvalid <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
`else
    logic unused_rd_inputs;

    assign ar_hs            = 1'b0;
    assign r_hs             = 1'b0;
    assign rd_bad           = 1'b0;
    assign m_axi_arvalid    = 1'b0;
    assign m_axi_rready     = 1'b0;
    assign m_axi_araddr     = BASE_ADDR;
    assign unused_rd_inputs = ^{m_axi_rdata, m_axi_rresp, m_axi_rvalid, m_axi_arready};
`endif

endmodule
`default_nettype wire

// File: tb/tb_axilite_master_traffic_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_axilite_master_traffic_gen
// Brief    : Randomised memory-slave bench with a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axilite_master_traffic_gen;

    localparam int          N      = 8;
    localparam logic [63:0] BASE   = 64'hFFFF_FFFF_FFFF_FFE8;
    localparam logic [63:0] STRIDE = 64'd8;
    localparam logic [63:0] SEED   = 64'hFFFF_FFFF_FFFF_FFFD;
`ifdef AXILITE_TRAFFIC_GEN_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif
    localparam int RUN_CYC = RB ? 4 * N : 2 * N;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [63:0] awaddr, wdata, araddr, rdata;
    logic [7:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready, busy, done;
    logic [1:0]  bresp, rresp;
    logic [15:0] error_count;

    axilite_master_traffic_gen #(
        .ADDR_WIDTH(64), .DATA_WIDTH(64), .BASE_ADDR(BASE), .ADDR_STRIDE(STRIDE),
        .DATA_SEED(SEED), .NUM_TXNS(N), .ERR_WIDTH(16)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
        .m_axi_araddr(araddr), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready),
        .busy(busy), .done(done), .error_count(error_count)
    );

    always #5 clk = ~clk;

    int n_vectors = 0;
    int n_miscompares = 0;

    task automatic check_eq(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        n_vectors++;
        if (actual !== expected) begin
            n_miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Transaction-level model: transaction i targets BASE+i*STRIDE with SEED+i.
    function automatic logic [63:0] exp_addr(input int i);
        return BASE + 64'(i) * STRIDE;
    endfunction
    function automatic logic [63:0] exp_data(input int i);
        return SEED + 64'(i);
    endfunction

    logic [63:0] aw_q[$], w_q[$], ar_q[$];
    logic [7:0]  s_q[$];
    logic [63:0] mem [logic [63:0]];
    int n_b, n_r, proto_err, ar_seen;
    int mode, hold_at, b_issued, r_issued, bcnt, rcnt, aw_wait;
    logic [7:0] bad_b, bad_rresp, bad_rdata;

    bit aw_pend, w_pend, ar_pend, aw_hs_d, w_hs_d, ar_hs_d;
    logic [63:0] aw_hold, w_hold, ar_hold;

    // Monitor: beat capture and valid-stability checks on the pre-edge values.
    always @(posedge clk) begin
        if (rst) begin
            aw_pend = 0; w_pend = 0; ar_pend = 0;
            aw_hs_d = 0; w_hs_d = 0; ar_hs_d = 0;
        end else begin
            if (aw_pend && (!awvalid || awaddr != aw_hold)) proto_err++;
            if (w_pend && (!wvalid || wdata != w_hold)) proto_err++;
            if (ar_pend && (!arvalid || araddr != ar_hold)) proto_err++;
            if ((aw_hs_d && awvalid) || (w_hs_d && wvalid) || (ar_hs_d && arvalid)) proto_err++;
            aw_hs_d = awvalid && awready; aw_pend = awvalid && !awready; aw_hold = awaddr;
            w_hs_d  = wvalid && wready;   w_pend  = wvalid && !wready;   w_hold  = wdata;
            ar_hs_d = arvalid && arready; ar_pend = arvalid && !arready; ar_hold = araddr;
            if (awvalid && awready) aw_q.push_back(awaddr);
            if (wvalid && wready) begin
                w_q.push_back(wdata);
                s_q.push_back(wstrb);
            end
            if (arvalid && arready) ar_q.push_back(araddr);
            if (bvalid && bready) n_b++;
            if (rvalid && rready) n_r++;
            if (arvalid) ar_seen++;
        end
    end

    // Memory slave, driven on the falling edge.
    always @(negedge clk) begin
        case (mode)
            0: begin awready = 1; wready = 1; arready = 1; end
            1: begin
                awready = 1'($urandom_range(0, 1));
                wready  = 1'($urandom_range(0, 1));
                arready = 1'($urandom_range(0, 1));
            end
            default: begin
                wready = 1; arready = 1;
                if (w_q.size() > aw_q.size()) aw_wait++; else aw_wait = 0;
                awready = (aw_wait >= 3);
            end
        endcase
        if (bvalid && n_b == b_issued) bvalid = 0;
        if (!bvalid && b_issued < aw_q.size() && b_issued < w_q.size() && b_issued != hold_at) begin
            if (bcnt > 0) bcnt--;
            else begin
                mem[aw_q[b_issued]] = w_q[b_issued];
                bresp  = (b_issued < 8 && bad_b[b_issued]) ? 2'b10 : 2'b00;
                bvalid = 1;
                b_issued++;
                bcnt = (mode == 1) ? int'($urandom_range(0, 3)) : 0;
            end
        end
        if (rvalid && n_r == r_issued) rvalid = 0;
        if (!rvalid && r_issued < ar_q.size()) begin
            if (rcnt > 0) rcnt--;
            else begin
                rdata  = mem[ar_q[r_issued]] ^ {63'd0, (r_issued < 8 && bad_rdata[r_issued])};
                rresp  = (r_issued < 8 && bad_rresp[r_issued]) ? 2'b10 : 2'b00;
                rvalid = 1;
                r_issued++;
                rcnt = (mode == 1) ? int'($urandom_range(0, 3)) : 0;
            end
        end
    end

    task automatic slave_clear();
        aw_q.delete(); w_q.delete(); ar_q.delete(); s_q.delete(); mem.delete();
        n_b = 0; n_r = 0; b_issued = 0; r_issued = 0; bcnt = 0; rcnt = 0;
        aw_wait = 0; proto_err = 0; ar_seen = 0;
        bvalid = 0; rvalid = 0; bresp = 0; rresp = 0; rdata = 0;
    endtask

    task automatic do_run(input int md, input logic [7:0] bb, input logic [7:0] rr,
                          input logic [7:0] rd, input bit timed, input bit poke);
        int cyc;
        bit to;
        @(negedge clk); #1;
        mode = md; bad_b = bb; bad_rresp = rr; bad_rdata = rd; hold_at = -1;
        slave_clear();
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
        check_eq("busy_after_start", busy, 1);
        cyc = 0; to = 0;
        while (!done) begin
            if (cyc >= 1000) begin to = 1; break; end
            @(negedge clk); cyc++;
            if (poke) start = (cyc == 3);
        end
        start = 0;
        check_eq("run_timeout", to, 0);
        if (timed) check_eq("done_cycle", cyc, RUN_CYC);
        check_eq("error_count", error_count,
                 $countones(bb) + (RB ? $countones(rr | rd) : 0));
        check_eq("aw_beats", aw_q.size(), N);
        check_eq("w_beats", w_q.size(), N);
        check_eq("b_beats", n_b, N);
        check_eq("ar_beats", ar_q.size(), RB ? N : 0);
        check_eq("r_beats", n_r, RB ? N : 0);
        for (int i = 0; i < N; i++) begin
            if (i < aw_q.size()) check_eq($sformatf("awaddr[%0d]", i), aw_q[i], exp_addr(i));
            if (i < w_q.size()) begin
                check_eq($sformatf("wdata[%0d]", i), w_q[i], exp_data(i));
                check_eq($sformatf("wstrb[%0d]", i), s_q[i], 8'hFF);
            end
            if (i < ar_q.size()) check_eq($sformatf("araddr[%0d]", i), ar_q[i], exp_addr(i));
        end
        check_eq("busy_end", busy, 0);
        check_eq("done_end", done, 1);
        check_eq("protocol", proto_err, 0);
        if (!RB) check_eq("arvalid_seen", ar_seen, 0);
    endtask

    initial begin
        int k;
        rst = 1; start = 0; mode = 0; hold_at = -1;
        bad_b = 0; bad_rresp = 0; bad_rdata = 0;
        slave_clear();
        repeat (3) @(negedge clk);
        check_eq("rst_awvalid", awvalid, 0);
        check_eq("rst_wvalid", wvalid, 0);
        check_eq("rst_bready", bready, 0);
        check_eq("rst_arvalid", arvalid, 0);
        check_eq("rst_rready", rready, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_errcnt", error_count, 0);
        check_eq("rst_awaddr", awaddr, BASE);
        check_eq("rst_araddr", araddr, BASE);
        check_eq("rst_wdata", wdata, SEED);
        rst = 0;

        do_run(0, 8'h00, 8'h00, 8'h00, 1, 1);
        do_run(2, 8'h00, 8'h00, 8'h00, 0, 0);
        do_run(0, 8'b0010_0000, 8'h00, 8'b1100_0000, 1, 0);

        // Reset while waiting on the B response of transaction 4.
        @(negedge clk); #1;
        mode = 0; bad_b = 0; bad_rresp = 0; bad_rdata = 0;
        slave_clear();
        hold_at = 4;
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
        k = 0;
        while (!(bready && aw_q.size() == 5 && w_q.size() == 5) && k < 200) begin
            @(negedge clk); k++;
        end
        check_eq("reach_wr_resp4", k < 200, 1);
        rst = 1;
        @(negedge clk);
        check_eq("midrst_awvalid", awvalid, 0);
        check_eq("midrst_wvalid", wvalid, 0);
        check_eq("midrst_bready", bready, 0);
        check_eq("midrst_arvalid", arvalid, 0);
        check_eq("midrst_rready", rready, 0);
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_done", done, 0);
        rst = 0;
        do_run(0, 8'h00, 8'h00, 8'h00, 1, 0);

        for (int r = 0; r < 8; r++) begin
            do_run((r % 2 == 0) ? 1 : 2, 8'($urandom & $urandom & $urandom),
                   8'($urandom & $urandom & $urandom), 8'($urandom & $urandom), 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
`default_nettype wire
